// File: rtl/pwr_seq_pkg.sv
// Shared types and constants for the board power-on sequencer.
package pwr_seq_pkg;

    typedef enum logic [2:0] {
        SETTLE  = 3'd0,
        RAIL_ON = 3'd1,
        GAP     = 3'd2,
        HOLD    = 3'd3,
        RUN     = 3'd4,
        FAULT   = 3'd5
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_TIMEOUT = 2'b01;
    localparam logic [1:0] FC_DROP    = 2'b10;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for one asynchronous level signal; clears to 0 on reset.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the async input through the flop chain.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/power_on_sequencer.sv
// Board power-up sequencer: settle, enable rails one by one, hold, then release rst_out.
// Any rail timeout or power-good drop shuts all rails and latches a fault until cleared.
module power_on_sequencer
    import pwr_seq_pkg::*;
#(
    parameter int N_RAILS          = 3,
    parameter int SETTLE_CYC       = 1024,
    parameter int RAIL_TIMEOUT_CYC = 4096,
    parameter int RAIL_GAP_CYC     = 256,
    parameter int RST_HOLD_CYC     = 64,
    parameter int SYNC_STAGES      = 2
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic [N_RAILS-1:0] pg_in,
    input  logic               fault_clr,
    output logic [N_RAILS-1:0] rail_en,
    output logic               rst_out,
    output logic               seq_done,
    output logic               fault,
    output logic [1:0]         fault_code,
    output logic [2:0]         fault_idx
);

    localparam int MAX_CYC = max2(max2(SETTLE_CYC, RAIL_TIMEOUT_CYC),
                                  max2(RAIL_GAP_CYC, RST_HOLD_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    logic [1:0]         rst_sync;
    logic               rst_int_n;
    logic [N_RAILS-1:0] pg_s;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [2:0]         idx, idx_nxt;
    logic [N_RAILS-1:0] rail_en_nxt;
    logic               rst_out_nxt, seq_done_nxt, fault_nxt;
    logic [1:0]         fault_code_nxt;
    logic [2:0]         fault_idx_nxt;

    int                 drop_lim;
    logic               drop;
    logic [2:0]         drop_idx;
    logic               cur_pg;
    logic               trip;
    logic [1:0]         trip_code;
    logic [2:0]         trip_idx;

    // Reset synchronizer: assert immediately, release two clocks after rst_n rises.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    for (genvar g = 0; g < N_RAILS; g++) begin : g_pg_sync
        bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
            .clk_in (clk_in),
            .rst_n  (rst_int_n),
            .d      (pg_in[g]),
            .q      (pg_s[g])
        );
    end

    // Next-state and next-output logic; outputs are registered from the state being entered.
    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        rail_en_nxt    = rail_en;
        rst_out_nxt    = rst_out;
        seq_done_nxt   = seq_done;
        fault_nxt      = fault;
        fault_code_nxt = fault_code;
        fault_idx_nxt  = fault_idx;
        trip           = 1'b0;
        trip_code      = FC_NONE;
        trip_idx       = 3'd0;

        // Rails that must already be good in the current state.
        case (state)
            RAIL_ON:   drop_lim = int'(idx);
            GAP:       drop_lim = int'(idx) + 1;
            HOLD, RUN: drop_lim = N_RAILS;
            default:   drop_lim = 0;
        endcase

        // Scan downward so the lowest dropped rail is the one reported.
        drop     = 1'b0;
        drop_idx = 3'd0;
        for (int j = N_RAILS - 1; j >= 0; j--) begin
            if (j < drop_lim && !pg_s[j]) begin
                drop     = 1'b1;
                drop_idx = 3'(j);
            end
        end

        cur_pg = 1'b0;
        for (int j = 0; j < N_RAILS; j++) begin
            if (3'(j) == idx) cur_pg = pg_s[j];
        end

        case (state)
            SETTLE: begin
                if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                    state_nxt = RAIL_ON;
                    idx_nxt   = 3'd0;
                end
            end
            RAIL_ON: begin
                if (drop) begin
                    trip = 1'b1; trip_code = FC_DROP; trip_idx = drop_idx;
                end else if (cur_pg) begin
                    state_nxt = GAP;
                end else if (cnt == CNT_W'(RAIL_TIMEOUT_CYC - 1)) begin
                    trip = 1'b1; trip_code = FC_TIMEOUT; trip_idx = idx;
                end
            end
            GAP: begin
                if (drop) begin
                    trip = 1'b1; trip_code = FC_DROP; trip_idx = drop_idx;
                end else if (cnt == CNT_W'(RAIL_GAP_CYC - 1)) begin
                    if (idx == 3'(N_RAILS - 1)) begin
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = RAIL_ON;
                        idx_nxt   = idx + 3'd1;
                    end
                end
            end
            HOLD: begin
                if (drop) begin
                    trip = 1'b1; trip_code = FC_DROP; trip_idx = drop_idx;
                end else if (cnt == CNT_W'(RST_HOLD_CYC - 1)) begin
                    state_nxt    = RUN;
                    rst_out_nxt  = 1'b0;
                    seq_done_nxt = 1'b1;
                end
            end
            RUN: begin
                if (drop) begin
                    trip = 1'b1; trip_code = FC_DROP; trip_idx = drop_idx;
                end
            end
            FAULT: begin
                if (fault_clr && pg_s == '0) begin
                    state_nxt      = SETTLE;
                    fault_nxt      = 1'b0;
                    fault_code_nxt = FC_NONE;
                    fault_idx_nxt  = 3'd0;
                end
            end
            default: begin
                state_nxt = SETTLE;
            end
        endcase

        if (trip) begin
            state_nxt      = FAULT;
            rail_en_nxt    = '0;
            rst_out_nxt    = 1'b1;
            seq_done_nxt   = 1'b0;
            fault_nxt      = 1'b1;
            fault_code_nxt = trip_code;
            fault_idx_nxt  = trip_idx;
        end

        // Enable of the rail being sequenced goes high on the edge that enters RAIL_ON.
        if (state_nxt == RAIL_ON) begin
            for (int j = 0; j < N_RAILS; j++) begin
                if (3'(j) == idx_nxt) rail_en_nxt[j] = 1'b1;
            end
        end

        if (state_nxt != state) begin
            cnt_nxt = '0;
        end else if (state == RUN || state == FAULT) begin
            cnt_nxt = cnt;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk_in or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state      <= SETTLE;
            cnt        <= '0;
            idx        <= 3'd0;
            rail_en    <= '0;
            rst_out    <= 1'b1;
            seq_done   <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            fault_idx  <= 3'd0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            rail_en    <= rail_en_nxt;
            rst_out    <= rst_out_nxt;
            seq_done   <= seq_done_nxt;
            fault      <= fault_nxt;
            fault_code <= fault_code_nxt;
            fault_idx  <= fault_idx_nxt;
        end
    end

endmodule
